bs_input_chain: RTL

BS_INPUT_CHAIN -- requirements
Module: bs_input_chain

---
 rtl/bs_chain_pkg.sv | 16 +
 rtl/bs_chain_counter.sv | 44 ++++
 rtl/bs_input_chain.sv | 103 ++++++++++
 3 files changed

// File: rtl/bs_chain_pkg.sv
// Shared constants and helpers for the boundary-scan input chain.
package bs_chain_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Constant-foldable ceil(log2(value)); used to size counters at elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bs_chain_counter.sv
// Saturating shift counter for the boundary-scan chain, cleared on capture,
// with a full flag raised once WIDTH shifts have been seen.
module bs_chain_counter
    import bs_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             tck_i,
    input  logic             trst_n_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == COUNT_MAX);

endmodule

// File: rtl/bs_input_chain.sv
// Boundary-scan input cell chain with 1-bit bypass and negedge TDO/update.
// Optional capture parity output is enabled by defining BS_CHAIN_PARITY_EN.
module bs_input_chain
    import bs_chain_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic [WIDTH-1:0] InputPins,
    input  logic             TDI,
    input  logic             CaptureDR,
    input  logic             ShiftDR,
    input  logic             UpdateDR,
    input  logic             Bypass,
    output logic             TDO,
    output logic [WIDTH-1:0] UpdateReg,
    output logic [CNT_W-1:0] ShiftCount,
`ifdef BS_CHAIN_PARITY_EN
    output logic             CaptureParity,
`endif
    output logic             ChainFull
);

    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic             bypass_q, bypass_d;
    logic             tdo_q;
    logic [WIDTH-1:0] update_q;
    logic             chain_shift;

    // Capture wins over shift; a bypass shift only moves the single bypass bit.
    assign chain_shift = !CaptureDR && ShiftDR && !Bypass;

    always_comb begin
        shift_reg_d = shift_reg_q;
        bypass_d    = bypass_q;
        if (CaptureDR) begin
            shift_reg_d = InputPins;
            bypass_d    = 1'b0;
        end else if (ShiftDR) begin
            if (Bypass) begin
                bypass_d = TDI;
            end else begin
                shift_reg_d = {TDI, shift_reg_q[WIDTH-1:1]};
            end
        end
    end

    // NOTE: only control/data flops are reset here; there are no memory arrays needing a reset-free style.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            shift_reg_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            shift_reg_q <= shift_reg_d;
            bypass_q    <= bypass_d;
        end
    end

    // Output side runs on the falling edge to give the next device half a cycle of hold.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            update_q <= '0;
        end else begin
            tdo_q <= Bypass ? bypass_q : shift_reg_q[0];
            if (UpdateDR && !Bypass) begin
                update_q <= shift_reg_q;
            end
        end
    end

    bs_chain_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .tck_i    (TCK),
        .trst_n_i (TRST),
        .clear_i  (CaptureDR),
        .inc_i    (chain_shift),
        .count_o  (ShiftCount),
        .full_o   (ChainFull)
    );

`ifdef BS_CHAIN_PARITY_EN
    logic parity_q;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            parity_q <= 1'b0;
        end else if (CaptureDR) begin
            parity_q <= ^InputPins;
        end
    end

    assign CaptureParity = parity_q;
`endif

    assign TDO       = tdo_q;
    assign UpdateReg = update_q;

endmodule
